// File: rtl/fp16_pkg.sv
// Shared binary16 constants, field layout and operand classifiers.
// Pure definitions: no latency and no flow control of its own.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int MANT_W   = 11;
    localparam int EXP_BIAS = 15;

    localparam logic [EXP_W-1:0] EXP_MAX      = 5'h1F;
    localparam logic [15:0]      FP16_QNAN    = 16'h7E00;
    localparam logic [15:0]      FP16_POS_INF = 16'h7C00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Subnormals count as zero: the datapath flushes them on input.
    function automatic logic is_zero(input fp16_t x);
        return (x.exp == '0);
    endfunction

    function automatic logic is_inf(input fp16_t x);
        return (x.exp == EXP_MAX) && (x.frac == '0);
    endfunction

    function automatic logic is_nan(input fp16_t x);
        return (x.exp == EXP_MAX) && (x.frac != '0);
    endfunction

endpackage

// File: rtl/floating_point_multiplier_booth.sv
// Unsigned 11x11 -> 22-bit multiplier: radix-4 Booth partial products, CSA tree, final adder.
// Purely combinational; no latency and no backpressure.
module booth_wallace_mult_11x11 (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [21:0] p
);

    localparam int PP_N = 6;
    localparam int W    = 22;

    // All arithmetic is modulo 2^22; the true product always fits, so sign
    // extension of negative Booth rows wraps away cleanly.
    logic [12:0]  yx;
    logic [W-1:0] pp [PP_N];

    assign yx = {1'b0, b, 1'b0};

    for (genvar i = 0; i < PP_N; i++) begin : g_pp
        logic [2:0]   grp;
        logic [W-1:0] mag;
        logic         neg;

        assign grp = yx[2*i+2 -: 3];

        always_comb begin
            mag = '0;
            neg = 1'b0;
            case (grp)
                3'b001, 3'b010: mag = W'(a);
                3'b011:         mag = W'({a, 1'b0});
                3'b100: begin
                    mag = W'({a, 1'b0});
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = W'(a);
                    neg = 1'b1;
                end
                default: ;
            endcase
        end

        assign pp[i] = (neg ? (~mag + 1'b1) : mag) << (2 * i);
    end

    function automatic logic [W-1:0] csa_sum(input logic [W-1:0] x, y, z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [W-1:0] csa_carry(input logic [W-1:0] x, y, z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [W-1:0] s0, c0, s1, c1, s2, c2, s3, c3;

    assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);
    assign s2 = csa_sum  (s0, c0, s1);
    assign c2 = csa_carry(s0, c0, s1);
    assign s3 = csa_sum  (s2, c2, c1);
    assign c3 = csa_carry(s2, c2, c1);

    assign p = s3 + c3;

endmodule

// File: rtl/floating_point_multiplier.sv
// Pipelined binary16 multiplier, result = A*B, RNE rounding, flush-to-zero.
// Latency 2 cycles; no backpressure, a new operand pair is accepted every cycle.
module floating_point_multiplier
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] result
);

    fp16_t fa, fb;
    assign fa = A;
    assign fb = B;

    logic [21:0]       prod_d;
    logic signed [6:0] exp_d;
    logic              nan_d, inf_d, zero_d;

    booth_wallace_mult_11x11 u_mult (
        .a (MANT_W'({1'b1, fa.frac})),
        .b (MANT_W'({1'b1, fb.frac})),
        .p (prod_d)
    );

    // Range -15..47 before normalise/round, so 7-bit signed never wraps.
    assign exp_d  = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 7'sd15;
    assign nan_d  = is_nan(fa) | is_nan(fb)
                  | (is_inf(fa) & is_zero(fb)) | (is_inf(fb) & is_zero(fa));
    assign inf_d  = is_inf(fa) | is_inf(fb);
    assign zero_d = is_zero(fa) | is_zero(fb);

    logic              s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [6:0] s1_exp;
    logic [21:0]       s1_prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
            s1_exp  <= '0;
            s1_prod <= '0;
        end else begin
            s1_sign <= fa.sign ^ fb.sign;
            s1_nan  <= nan_d;
            s1_inf  <= inf_d;
            s1_zero <= zero_d;
            s1_exp  <= exp_d;
            s1_prod <= prod_d;
        end
    end

    logic signed [6:0]   e_norm, e_rnd;
    logic [FRAC_W-1:0]   frac_t;
    logic [FRAC_W:0]     frac_sum;
    logic                guard, sticky, rnd_up;
    logic [15:0]         res_d;

    always_comb begin
        e_norm = s1_exp;
        frac_t = s1_prod[19:10];
        guard  = s1_prod[9];
        sticky = |s1_prod[8:0];
        if (s1_prod[21]) begin
            e_norm = s1_exp + 7'sd1;
            frac_t = s1_prod[20:11];
            guard  = s1_prod[10];
            sticky = |s1_prod[9:0];
        end

        rnd_up   = guard & (sticky | frac_t[0]);
        frac_sum = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd_up};
        // A carry out leaves frac_sum[9:0] at zero, i.e. mantissa 1.0 of the next binade.
        e_rnd    = frac_sum[FRAC_W] ? (e_norm + 7'sd1) : e_norm;

        res_d = {s1_sign, e_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        if (s1_nan)
            res_d = FP16_QNAN;
        else if (s1_inf)
            res_d = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
        else if (s1_zero)
            res_d = {s1_sign, 15'h0000};
        else if (e_rnd >= 7'sd31)
            res_d = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
        else if (e_rnd <= 7'sd0)
            res_d = {s1_sign, 15'h0000};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            result <= 16'h0000;
        else
            result <= res_d;
    end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Bench for floating_point_multiplier: directed vector table, reset sequences,
// and random operands against an integer-arithmetic binary16 reference.
module tb_floating_point_multiplier;

    logic        clk;
    logic        rst;
    logic [15:0] A, B;
    logic [15:0] result;

    floating_point_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        bit          chk;
        int          tag;
    } pend_t;

    pend_t pend_q[$];

    task automatic check(input string name, input int tag, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: result=%h expected=%h", name, tag, act, exp);
        end
    endtask

    // Reference: exact integer product, rounded to nearest-even by remainder comparison.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, fa, fb, e, sh;
        longint p, q, rem, half;
        bit   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);  eb = int'(b[14:10]);
        fa = int'(a[9:0]);    fb = int'(b[9:0]);
        a_nan  = (ea == 31) && (fa != 0);  b_nan  = (eb == 31) && (fb != 0);
        a_inf  = (ea == 31) && (fa == 0);  b_inf  = (eb == 31) && (fb == 0);
        a_zero = (ea == 0);                b_zero = (eb == 0);
        if (a_nan || b_nan) return 16'h7E00;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
        if (a_inf || b_inf) return {s, 15'h7C00};
        if (a_zero || b_zero) return {s, 15'h0000};
        p  = longint'(1024 + fa) * longint'(1024 + fb);
        e  = ea + eb - 15;
        sh = 10;
        if (p >= 64'd2097152) begin
            e++;
            sh = 11;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0)  return {s, 15'h0000};
        return {s, 5'(e), 10'(q - 1024)};
    endfunction

    // Compares the output due this cycle, then applies the next operand pair.
    task automatic cycle(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input bit chk, input int tag);
        pend_t e;
        @(negedge clk);
        if (pend_q.size() == 2) begin
            e = pend_q.pop_front();
            if (e.chk) check("pipe", e.tag, result, e.exp);
        end
        A = a;
        B = b;
        pend_q.push_back('{exp, chk, tag});
    endtask

    // While reset is held, outputs must stay zero no matter what A/B do.
    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            A = 16'(32'h3C00 + i * 32'h1111);
            B = 16'(32'hC400 - i * 32'h0777);
            #1 check("rst_hold", i, result, 16'h0000);
        end
    endtask

    // The first output after release comes from cleared state: must be zero.
    task automatic release_reset;
        @(negedge clk);
        rst = 1'b1;
        A   = 16'h4000;
        B   = 16'h4000;
        pend_q.delete();
        pend_q.push_back('{16'h0000, 1'b1, 900});
        pend_q.push_back('{16'h4400, 1'b1, 901});
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] ra, rb;

        vecs.push_back('{16'h39FE, 16'hBD5A, 16'hBC02});
        vecs.push_back('{16'hC200, 16'h4000, 16'hC600});
        vecs.push_back('{16'hC000, 16'hC000, 16'h4400});
        vecs.push_back('{16'h4200, 16'h0000, 16'h0000});
        vecs.push_back('{16'hC200, 16'h0000, 16'h8000});
        vecs.push_back('{16'h7C00, 16'h0000, 16'h7E00});
        vecs.push_back('{16'h7BFF, 16'h4000, 16'h7C00});
        vecs.push_back('{16'h0400, 16'h0400, 16'h0000});
        vecs.push_back('{16'h7E01, 16'h3C00, 16'h7E00});
        vecs.push_back('{16'h3C00, 16'h7E01, 16'h7E00});
        vecs.push_back('{16'hFC00, 16'h4000, 16'hFC00});
        vecs.push_back('{16'h7C00, 16'hC000, 16'hFC00});
        vecs.push_back('{16'h0000, 16'hFC00, 16'h7E00});
        vecs.push_back('{16'h0001, 16'h7C00, 16'h7E00});
        vecs.push_back('{16'h0200, 16'h3C00, 16'h0000});
        vecs.push_back('{16'h3C01, 16'h3C01, 16'h3C02});
        vecs.push_back('{16'h3BFF, 16'h3C01, 16'h3C00});
        vecs.push_back('{16'h3E00, 16'h3E00, 16'h4080});
        vecs.push_back('{16'h3C00, 16'h8000, 16'h8000});

        rst = 1'b0;
        A   = 16'h0000;
        B   = 16'h0000;
        #1 check("rst_t0", 0, result, 16'h0000);
        hold_reset(2);
        release_reset();

        foreach (vecs[i]) cycle(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, i);

        // Mid-stream asynchronous reset: in-flight products must vanish.
        cycle(16'h4200, 16'h4200, 16'h4880, 1'b0, 100);
        cycle(16'h4400, 16'h4400, 16'h4C00, 1'b0, 101);
        #2 rst = 1'b0;
        #1 check("rst_async", 0, result, 16'h0000);
        hold_reset(2);
        release_reset();

        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 2 == 0) begin
                ra[14:10] = 5'($urandom_range(6, 24));
                rb[14:10] = 5'($urandom_range(6, 24));
            end
            cycle(ra, rb, ref_mul(ra, rb), 1'b1, 1000 + i);
        end

        cycle(16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        cycle(16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        cycle(16'h0000, 16'h0000, 16'h0000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
